irq_controller: RTL and testbench

//   Memory-mapped interrupt controller downstream of the GPIO/timer peripheral.

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_src_sync.sv | 38 +++
 rtl/irq_controller.sv | 162 ++++++++++++++++
 tb/tb_irq_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encodings and the priority helper.
package irq_pkg;

  localparam int VEC_W = 3;

  // Register offsets from the base address
  localparam logic [2:0] OFF_ENABLE  = 3'd0;
  localparam logic [2:0] OFF_PENDING = 3'd1;
  localparam logic [2:0] OFF_EDGE    = 3'd2;
  localparam logic [2:0] OFF_CTRL    = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;
  localparam logic [2:0] OFF_EOI     = 3'd5;

  // FSM state encodings; these are visible to software through STATUS[7:6]
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  // Index of the lowest set bit. Bit 0 has the highest priority.
  function automatic logic [VEC_W-1:0] lowest_index(input logic [7:0] bits);
    lowest_index = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) lowest_index = VEC_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_src_sync.sv
// Per-bit two-flop synchroniser followed by a one-flop delay used to
// detect rising edges on the synchronised lines.
module irq_src_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;
  logic [W-1:0] dly_reg;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      // Synchroniser chain plus edge-detect delay for one source bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
          dly_reg[gi]  <= 1'b0;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
          dly_reg[gi]  <= sync_reg[gi];
        end
      end

      assign level[gi] = sync_reg[gi];
      assign rise[gi]  = sync_reg[gi] & ~dly_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: register file, pending latches,
// fixed-priority arbitration and the IDLE/REQ/SVC request FSM.
module irq_controller
  import irq_pkg::*;
#(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] BASE_ADDR = 8'h08
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         din,
  input  logic [7:0]         address,
  input  logic               w_en,
  input  logic               r_en,
  output logic [7:0]         dout,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  input  logic               irq_ack
);

  // Bits at or above NUM_SRC never exist in any per-source register
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  logic [7:0]       enable_reg;
  logic [7:0]       pending_reg;
  logic [7:0]       pending_next;
  logic [7:0]       edge_reg;
  logic             ctrl_en_reg;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [VEC_W-1:0] vector_reg;

  logic [NUM_SRC-1:0] src_level;
  logic [NUM_SRC-1:0] src_rise;
  logic [7:0]         level_ext;
  logic [7:0]         rise_ext;
  logic [7:0]         set_bits;
  logic [7:0]         w1c_bits;
  logic [7:0]         ack_clr;
  logic [7:0]         active;
  logic [7:0]         rd_data;

  logic [8:0] addr_off;
  logic       hit;
  logic [2:0] offset;
  logic       wr_hit;
  logic       eoi_wr;

  irq_src_sync #(.W(NUM_SRC)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (src),
    .level (src_level),
    .rise  (src_rise)
  );

  assign level_ext = 8'(src_level);
  assign rise_ext  = 8'(src_rise);

  // Address window decode; the 9-bit subtraction keeps addresses below the base out
  assign addr_off = {1'b0, address} - {1'b0, BASE_ADDR};
  assign hit      = (address >= BASE_ADDR) && (addr_off < 9'd6);
  assign offset   = addr_off[2:0];
  assign wr_hit   = w_en && hit;
  assign eoi_wr   = wr_hit && (offset == OFF_EOI);

  assign active = pending_reg & enable_reg;

  // Pending update: new events win over both W1C and acknowledge clears
  always_comb begin
    set_bits     = ((edge_reg & rise_ext) | (~edge_reg & level_ext)) & SRC_MASK;
    w1c_bits     = (wr_hit && (offset == OFF_PENDING)) ? din : 8'h00;
    pending_next = ((pending_reg & ~w1c_bits & ~ack_clr) | set_bits) & SRC_MASK;
  end

  // Register file writes and pending latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg  <= 8'h00;
      edge_reg    <= 8'h00;
      ctrl_en_reg <= 1'b0;
      pending_reg <= 8'h00;
    end else begin
      pending_reg <= pending_next;
      if (wr_hit) begin
        case (offset)
          OFF_ENABLE: enable_reg  <= din & SRC_MASK;
          OFF_EDGE:   edge_reg    <= din & SRC_MASK;
          OFF_CTRL:   ctrl_en_reg <= din[0];
          default:    ;
        endcase
      end
    end
  end

  // State register and vector latch taken on entry to REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      vector_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && state_next == ST_REQ) begin
        vector_reg <= lowest_index(active);
      end
    end
  end

  // Next-state logic; an acknowledge takes precedence over a withdrawn request
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ctrl_en_reg && (active != 8'h00)) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_next = ST_SVC;
        end else if (!ctrl_en_reg || !enable_reg[vector_reg] || !pending_reg[vector_reg]) begin
          state_next = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (eoi_wr) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: request level and the pending bit cleared by acknowledge
  always_comb begin
    irq     = (state_reg == ST_REQ);
    ack_clr = 8'h00;
    if (state_reg == ST_REQ && irq_ack) ack_clr = 8'h01 << vector_reg;
  end

  assign vector = vector_reg;

  // Read mux
  always_comb begin
    rd_data = 8'h00;
    case (offset)
      OFF_ENABLE:  rd_data = enable_reg;
      OFF_PENDING: rd_data = pending_reg;
      OFF_EDGE:    rd_data = edge_reg;
      OFF_CTRL:    rd_data = {7'b0, ctrl_en_reg};
      OFF_STATUS:  rd_data = {state_reg, 3'b000, vector_reg};
      default:     rd_data = 8'h00;
    endcase
  end

  // Registered read data, held between decoded reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 8'h00;
    end else if (r_en && hit) begin
      dout <= rd_data;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller.
module tb_irq_controller;

  localparam logic [7:0] BASE = 8'h08;
  localparam logic [7:0] A_ENABLE  = BASE + 8'd0;
  localparam logic [7:0] A_PENDING = BASE + 8'd1;
  localparam logic [7:0] A_EDGE    = BASE + 8'd2;
  localparam logic [7:0] A_CTRL    = BASE + 8'd3;
  localparam logic [7:0] A_STATUS  = BASE + 8'd4;
  localparam logic [7:0] A_EOI     = BASE + 8'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [7:0] src;
  logic       irq;
  logic [2:0] vector;
  logic       irq_ack;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .address (address),
    .w_en    (w_en),
    .r_en    (r_en),
    .dout    (dout),
    .src     (src),
    .irq     (irq),
    .vector  (vector),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    address = a;
    din     = d;
    w_en    = 1'b1;
    tick();
    w_en    = 1'b0;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    address = a;
    r_en    = 1'b1;
    tick();
    r_en    = 1'b0;
    d       = dout;
    $display("rd addr=%h data=%h", a, d);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    $display("ack");
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    rst = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
    src = 8'h00; irq_ack = 1'b0;
    #12;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_rd(BASE + 8'(i), rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", i, rd); end
    end
    // Reach REQ with vector 4, then reset asynchronously
    bus_wr(A_ENABLE, 8'h10);
    bus_wr(A_EDGE, 8'h10);
    bus_wr(A_CTRL, 8'h01);
    bus_rd(A_ENABLE, rd);
    src = 8'h10; tick(); src = 8'h00;
    repeat (3) tick();
    checks++; if (irq !== 1'b1 || vector !== 3'd4) begin errors++; $display("FAIL pre_reset_req got irq=%b vec=%0d want irq=1 vec=4", irq, vector); end
    #2 rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0 || vector !== 3'd0) begin errors++; $display("FAIL midreq_reset got irq=%b vec=%0d want irq=0 vec=0", irq, vector); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midreq_reset_dout got %h want 00", dout); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_rd(BASE + 8'(i), rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL post_reset_reg%0d got %h want 00", i, rd); end
    end
  endtask

  task automatic test_edge_single();
    logic [7:0] rd;
    bus_wr(A_ENABLE, 8'h01);
    bus_wr(A_EDGE, 8'h01);
    bus_wr(A_CTRL, 8'h01);
    src = 8'h01; tick(); src = 8'h00;
    tick();
    bus_rd(A_PENDING, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL edge_pend_early got %h want 00", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early got %b want 0", irq); end
    bus_rd(A_PENDING, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL edge_pend got %h want 01", rd); end
    checks++; if (irq !== 1'b1 || vector !== 3'd0) begin errors++; $display("FAIL edge_req got irq=%b vec=%0d want irq=1 vec=0", irq, vector); end
    ack();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_ack_irq got %b want 0", irq); end
    bus_rd(A_PENDING, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL edge_ack_pend got %h want 00", rd); end
    bus_rd(A_STATUS, rd);
    checks++; if (rd !== 8'h80) begin errors++; $display("FAIL edge_svc_status got %h want 80", rd); end
    bus_wr(A_EOI, 8'h00);
    bus_rd(A_STATUS, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL edge_eoi_status got %h want 00", rd); end
  endtask

  task automatic test_priority();
    logic [7:0] rd;
    bus_wr(A_ENABLE, 8'hFF);
    bus_wr(A_EDGE, 8'hFF);
    src = 8'h24; tick(); src = 8'h00;
    repeat (3) tick();
    checks++; if (irq !== 1'b1 || vector !== 3'd2) begin errors++; $display("FAIL prio_first got irq=%b vec=%0d want irq=1 vec=2", irq, vector); end
    src = 8'h01; tick(); src = 8'h00;
    repeat (3) tick();
    checks++; if (irq !== 1'b1 || vector !== 3'd2) begin errors++; $display("FAIL prio_hold got irq=%b vec=%0d want irq=1 vec=2", irq, vector); end
    ack();
    bus_wr(A_EOI, 8'h00);
    tick();
    checks++; if (irq !== 1'b1 || vector !== 3'd0) begin errors++; $display("FAIL prio_second got irq=%b vec=%0d want irq=1 vec=0", irq, vector); end
    ack();
    bus_wr(A_EOI, 8'h00);
    tick();
    checks++; if (irq !== 1'b1 || vector !== 3'd5) begin errors++; $display("FAIL prio_third got irq=%b vec=%0d want irq=1 vec=5", irq, vector); end
    ack();
    bus_wr(A_EOI, 8'h00);
    bus_rd(A_STATUS, rd);
    checks++; if (rd !== 8'h05) begin errors++; $display("FAIL prio_idle_status got %h want 05", rd); end
  endtask

  task automatic test_level_mask();
    logic [7:0] rd;
    bus_wr(A_EDGE, 8'h00);
    bus_wr(A_ENABLE, 8'h00);
    src = 8'h08;
    repeat (4) tick();
    bus_rd(A_PENDING, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL level_pend got %h want 08", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_masked_irq got %b want 0", irq); end
    bus_wr(A_ENABLE, 8'h08);
    tick();
    checks++; if (irq !== 1'b1 || vector !== 3'd3) begin errors++; $display("FAIL level_req got irq=%b vec=%0d want irq=1 vec=3", irq, vector); end
    bus_wr(A_ENABLE, 8'h00);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_unmask_irq got %b want 0", irq); end
    bus_rd(A_STATUS, rd);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL level_idle_status got %h want 03", rd); end
    src = 8'h00;
    repeat (3) tick();
    bus_wr(A_PENDING, 8'h08);
    bus_rd(A_PENDING, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL level_w1c got %h want 00", rd); end
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    bus_wr(A_EDGE, 8'h02);
    src = 8'h02; tick(); src = 8'h00;
    tick();
    bus_wr(A_PENDING, 8'h02);
    bus_rd(A_PENDING, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL collide_set_wins got %h want 02", rd); end
    bus_wr(A_PENDING, 8'h02);
    bus_rd(A_PENDING, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL collide_w1c got %h want 00", rd); end
  endtask

  task automatic test_bus_decode();
    logic [7:0] rd;
    bus_wr(A_ENABLE, 8'h5A);
    bus_rd(A_ENABLE, rd);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL decode_enable got %h want 5a", rd); end
    bus_wr(BASE - 8'd1, 8'hFF);
    bus_wr(BASE + 8'd6, 8'hFF);
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL decode_dout_hold got %h want 5a", dout); end
    bus_rd(BASE + 8'd6, rd);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL decode_oob_read got %h want 5a", rd); end
    bus_rd(A_ENABLE, rd);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL decode_enable_kept got %h want 5a", rd); end
    bus_rd(A_EDGE, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL decode_edge_kept got %h want 02", rd); end
    bus_rd(A_CTRL, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL decode_ctrl_kept got %h want 01", rd); end
    bus_wr(A_ENABLE, 8'h33);
    address = A_ENABLE;
    r_en = 1'b1;
    #1;
    checks++; if (dout !== 8'h01) begin errors++; $display("FAIL read_latency_before got %h want 01", dout); end
    tick();
    r_en = 1'b0;
    checks++; if (dout !== 8'h33) begin errors++; $display("FAIL read_latency_after got %h want 33", dout); end
    $display("rd addr=%h data=%h", A_ENABLE, dout);
  endtask

  initial begin
    test_reset();
    test_edge_single();
    test_priority();
    test_level_mask();
    test_collision();
    test_bus_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
